mc_core: RTL and testbench
==========================

Name: mc_core

Overview:
- Multi-cycle, non-pipelined 32-bit CPU core implementing the team's 5-bit-opcode RISC ISA.
- Connects to an external register file with combinational reads and writes on the clock edge.
- Connects to a synchronous-read instruction ROM and a synchronous-read/write data RAM; both are word-addressed and register on the same clock edge.
- Sits between the ROM, RAM and register file in the top-level wrapper. Memory-mapped I/O (e.g. addresses 1000/2000) is decoded outside the core.

Parameters:
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- address_imem  out  32  instruction word address (= PC).
- q_imem  in  32  ROM data, registered by the ROM one edge after the address is presented.
- ctrl_writeEnable  out  1  regfile write enable.
- ctrl_writeReg  out  5  regfile write index.
- ctrl_readRegA  out  5  regfile read index A.
- ctrl_readRegB  out  5  regfile read index B.
- data_writeReg  out  32  regfile write data.
- data_readRegA  in  32  combinational read data A.
- data_readRegB  in  32  combinational read data B.
- wren  out  1  RAM write enable.
- address_dmem  out  32  RAM word address (effective address).
- data  out  32  RAM write data.
- q_dmem  in  32  RAM read data, registered one edge after the address is presented.

Behaviour:
- Encoding:
  - op = [31:27], rd = [26:22], rs = [21:17], rt = [16:12], shamt = [11:7], aluop = [6:2].
  - N = sign-extended [16:0]. T = zero-extended [26:0].
- Opcodes: 00000 R-type, 00101 addi, 00111 sw, 01000 lw, 00001 j, 00010 bne, 00011 jal, 00100 jr, 00110 blt, 10110 bex, 10101 setx.
- R-type aluop: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll (by shamt), 00101 sra (by shamt).
- Any other opcode or aluop, including mul/div, executes as a nop: no writes, PC+1.
- FSM states:
  - FETCH: drive address_imem = PC; go to DECODE.
  - DECODE: latch IR <= q_imem; go to EXEC.
  - EXEC: drive read indices from IR and compute. Writeback/store/PC update occur at the closing edge. Go to FETCH, or to MEM for lw.
  - MEM: data_writeReg = q_dmem, write rd; PC+1; go to FETCH.
- Latency: 3 cycles per instruction; lw takes 4.
- Read ports:
  - A = rs; A = 30 for bex.
  - B = rt for R-type; B = rd for sw, bne, blt, jr.
- Semantics:
  - add/sub/and/or/sll/sra/addi: rd <= result.
  - sw: MEM[rs+N] <= rd. Assert wren, address_dmem, data in EXEC only.
  - lw: address_dmem = rs+N in EXEC; rd <= q_dmem in MEM.
  - j: PC <= T. jal: r31 <= PC+1, PC <= T. jr: PC <= rd.
  - bne: if rd != rs, PC <= PC+1+N. blt: if rd < rs (signed), PC <= PC+1+N. Otherwise PC+1.
  - bex: if r30 != 0, PC <= T. setx: r30 <= T.
- Overflow (signed):
  - add overflow writes 1 to r30 instead of rd.
  - addi overflow writes 2 to r30.
  - sub overflow writes 3 to r30.
- ctrl_writeEnable is never asserted with write index 0. Writes to r0 are suppressed.
- Arithmetic is 32-bit two's complement and wraps. PC increments wrap at 2^32.
- ctrl_writeEnable and wren are 1 only in their single write cycle; 0 otherwise.
- Reset: PC = RESET_PC, IR = 0, state = FETCH, ctrl_writeEnable = 0, wren = 0, all other outputs 0 except address_imem = RESET_PC. Reset mid-instruction aborts it with no write.

Decomposition:
- Shared package mc_pkg: opcode and aluop constants, FSM state enum, rstatus index 30 and link index 31, overflow codes 1/2/3.
- One sub-module, mc_alu: combinational add/sub/and/or/sll/sra/lt/ne, plus overflow flag.

Test Plan:
- addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 -> r3 = 12. Writes at cycles 3, 6, 9 after reset; wren stays 0.
- addi r1,r0,-1 (N = 0x1FFFF); sra r2,r1,4; sll r3,r1,31 -> r1 = -1, r2 = -1, r3 = 0x80000000.
- r1 = 0x7FFFFFFF via sll/or sequence; add r2,r1,r1 -> r30 = 1, r2 unchanged. sub 0x80000000 - 1 -> r30 = 3.
- addi r1,r0,9; sw r1,4(r0); lw r2,4(r0) -> wren = 1 for one cycle with address 4, data 9; r2 = 9; lw takes 4 cycles.
- bne taken over one addi, blt not taken, jal to 10, jr r31 -> skipped register unchanged; r31 = PC+1; execution resumes after the jal.
- setx 3; bex 20 -> r30 = 3, PC = 20. Assert reset during EXEC of an add -> no write; PC = 0 next cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the mc_core multi-cycle CPU: opcodes, ALU function
// codes, FSM states, special register indices and overflow status codes.
package mc_pkg;

   // Primary opcodes, instruction bits [31:27]
   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_J     = 5'b00001;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_SETX  = 5'b10101;
   localparam logic [4:0] OP_BEX   = 5'b10110;

   // R-type function codes, instruction bits [6:2]
   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;
   localparam logic [4:0] ALU_AND  = 5'b00010;
   localparam logic [4:0] ALU_OR   = 5'b00011;
   localparam logic [4:0] ALU_SLL  = 5'b00100;
   localparam logic [4:0] ALU_SRA  = 5'b00101;

   // Architecturally special registers
   localparam logic [4:0] REG_RSTATUS = 5'd30;
   localparam logic [4:0] REG_LINK    = 5'd31;

   // Values written to rstatus on signed overflow
   localparam logic [31:0] OVF_ADD  = 32'd1;
   localparam logic [31:0] OVF_ADDI = 32'd2;
   localparam logic [31:0] OVF_SUB  = 32'd3;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_MEM    = 2'd3
   } mc_state_e;

   // Function codes beyond sra (mul, div, reserved) execute as a nop
   function automatic logic alu_fn_valid(input logic [4:0] fn);
      return (fn <= ALU_SRA);
   endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for mc_core: add/sub/and/or/sll/sra selected by function
// code, plus signed overflow, signed less-than and not-equal flags.
module mc_alu (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [4:0]  i_fn,
   input  logic [4:0]  i_shamt,
   output logic [31:0] o_result,
   output logic        o_ovf,
   output logic        o_lt,
   output logic        o_ne
);
   import mc_pkg::*;

   logic [31:0] w_sum;
   logic [31:0] w_diff;
   logic        w_add_ovf;
   logic        w_sub_ovf;

   assign w_sum  = i_a + i_b;
   assign w_diff = i_a - i_b;

   // Signed overflow: operands agree (add) or differ (sub) in sign and the
   // result sign disagrees with operand a.
   assign w_add_ovf = (i_a[31] == i_b[31]) && (w_sum[31]  != i_a[31]);
   assign w_sub_ovf = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);

   assign o_lt = ($signed(i_a) < $signed(i_b));
   assign o_ne = (i_a != i_b);

   // Result and overflow select by function code
   always_comb begin
      o_result = '0;
      o_ovf    = 1'b0;
      case (i_fn)
         ALU_ADD: begin
            o_result = w_sum;
            o_ovf    = w_add_ovf;
         end
         ALU_SUB: begin
            o_result = w_diff;
            o_ovf    = w_sub_ovf;
         end
         ALU_AND: o_result = i_a & i_b;
         ALU_OR:  o_result = i_a | i_b;
         ALU_SLL: o_result = i_a << i_shamt;
         ALU_SRA: o_result = $signed(i_a) >>> i_shamt;
         default: begin
            o_result = '0;
            o_ovf    = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mc_core.sv
// mc_core: multi-cycle, non-pipelined 32-bit CPU core. Drives an external
// register file (combinational reads), a synchronous-read instruction ROM and
// a synchronous-read/write data RAM.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_FETCH  | PC presented on address_imem; ROM registers the word
//   ST_DECODE | ROM word latched into IR
//   ST_EXEC   | register reads, ALU, writeback/store/PC update at closing edge
//   ST_MEM    | lw only: RAM read data written to rd, PC advances
module mc_core #(
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] address_imem,
   input  logic [31:0] q_imem,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [4:0]  ctrl_readRegA,
   output logic [4:0]  ctrl_readRegB,
   output logic [31:0] data_writeReg,
   input  logic [31:0] data_readRegA,
   input  logic [31:0] data_readRegB,
   output logic        wren,
   output logic [31:0] address_dmem,
   output logic [31:0] data,
   input  logic [31:0] q_dmem
);
   import mc_pkg::*;

   mc_state_e   r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ir;

   logic [4:0]  w_op;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_shamt;
   logic [4:0]  w_aluop;
   logic [31:0] w_n;
   logic [31:0] w_t;
   logic        w_unused;

   logic [31:0] w_alu_a;
   logic [31:0] w_alu_b;
   logic [4:0]  w_alu_fn;
   logic [31:0] w_alu_result;
   logic        w_alu_ovf;
   logic        w_alu_lt;
   logic        w_alu_ne;

   logic [31:0] w_pc_inc;
   logic [31:0] w_pc_br;
   logic [31:0] w_next_pc;
   logic        w_we;
   logic [4:0]  w_wreg;
   logic [31:0] w_wdata;

   assign w_op    = r_ir[31:27];
   assign w_rd    = r_ir[26:22];
   assign w_rs    = r_ir[21:17];
   assign w_rt    = r_ir[16:12];
   assign w_shamt = r_ir[11:7];
   assign w_aluop = r_ir[6:2];
   assign w_n     = {{15{r_ir[16]}}, r_ir[16:0]};
   assign w_t     = {5'b0, r_ir[26:0]};

   // IR[1:0] carries no meaning in any instruction format
   assign w_unused = ^r_ir[1:0];

   assign address_imem = r_pc;
   assign w_pc_inc     = r_pc + 32'd1;
   assign w_pc_br      = w_pc_inc + w_n;

   // blt compares rd < rs, so rd (port B) goes on the ALU a side; R-type uses
   // rt, bne compares rs against rd, everything else adds the immediate.
   assign w_alu_a  = (w_op == OP_BLT) ? data_readRegB : data_readRegA;
   assign w_alu_fn = (w_op == OP_RTYPE) ? w_aluop : ALU_ADD;

   always_comb begin
      w_alu_b = w_n;
      case (w_op)
         OP_RTYPE: w_alu_b = data_readRegB;
         OP_BNE:   w_alu_b = data_readRegB;
         OP_BLT:   w_alu_b = data_readRegA;
         default:  w_alu_b = w_n;
      endcase
   end

   mc_alu u_alu (
      .i_a      (w_alu_a),
      .i_b      (w_alu_b),
      .i_fn     (w_alu_fn),
      .i_shamt  (w_shamt),
      .o_result (w_alu_result),
      .o_ovf    (w_alu_ovf),
      .o_lt     (w_alu_lt),
      .o_ne     (w_alu_ne)
   );

   // Per-state decode of register reads, writeback, memory access and next PC.
   // Everything is held at zero while reset is asserted so an aborted
   // instruction cannot write the register file or RAM at the reset edge.
   always_comb begin
      ctrl_readRegA = '0;
      ctrl_readRegB = '0;
      w_we          = 1'b0;
      w_wreg        = '0;
      w_wdata       = '0;
      w_next_pc     = w_pc_inc;
      wren          = 1'b0;
      address_dmem  = '0;
      data          = '0;
      if (!reset && r_state == ST_EXEC) begin
         ctrl_readRegA = (w_op == OP_BEX) ? REG_RSTATUS : w_rs;
         case (w_op)
            OP_RTYPE:                  ctrl_readRegB = w_rt;
            OP_SW, OP_BNE, OP_BLT, OP_JR: ctrl_readRegB = w_rd;
            default:                   ctrl_readRegB = '0;
         endcase
         case (w_op)
            OP_RTYPE: begin
               if (alu_fn_valid(w_aluop)) begin
                  w_we = 1'b1;
                  if (w_alu_ovf) begin
                     w_wreg  = REG_RSTATUS;
                     w_wdata = (w_aluop == ALU_SUB) ? OVF_SUB : OVF_ADD;
                  end else begin
                     w_wreg  = w_rd;
                     w_wdata = w_alu_result;
                  end
               end
            end
            OP_ADDI: begin
               w_we = 1'b1;
               if (w_alu_ovf) begin
                  w_wreg  = REG_RSTATUS;
                  w_wdata = OVF_ADDI;
               end else begin
                  w_wreg  = w_rd;
                  w_wdata = w_alu_result;
               end
            end
            OP_SW: begin
               wren         = 1'b1;
               address_dmem = w_alu_result;
               data         = data_readRegB;
            end
            OP_LW: address_dmem = w_alu_result;
            OP_J:  w_next_pc = w_t;
            OP_JAL: begin
               w_we      = 1'b1;
               w_wreg    = REG_LINK;
               w_wdata   = w_pc_inc;
               w_next_pc = w_t;
            end
            OP_JR: w_next_pc = data_readRegB;
            OP_BNE: if (w_alu_ne) w_next_pc = w_pc_br;
            OP_BLT: if (w_alu_lt) w_next_pc = w_pc_br;
            OP_BEX: if (data_readRegA != 32'd0) w_next_pc = w_t;
            OP_SETX: begin
               w_we    = 1'b1;
               w_wreg  = REG_RSTATUS;
               w_wdata = w_t;
            end
            default: w_we = 1'b0;
         endcase
      end else if (!reset && r_state == ST_MEM) begin
         w_we    = 1'b1;
         w_wreg  = w_rd;
         w_wdata = q_dmem;
      end
   end

   // r0 is hardwired: a write aimed at it is dropped entirely
   assign ctrl_writeEnable = w_we && (w_wreg != 5'd0);
   assign ctrl_writeReg    = ctrl_writeEnable ? w_wreg  : 5'd0;
   assign data_writeReg    = ctrl_writeEnable ? w_wdata : 32'd0;

   // Instruction sequencer: PC, IR and state
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_FETCH;
         r_pc    <= RESET_PC;
         r_ir    <= '0;
      end else begin
         case (r_state)
            ST_FETCH: r_state <= ST_DECODE;
            ST_DECODE: begin
               r_ir    <= q_imem;
               r_state <= ST_EXEC;
            end
            ST_EXEC: begin
               if (w_op == OP_LW) begin
                  r_state <= ST_MEM;
               end else begin
                  r_pc    <= w_next_pc;
                  r_state <= ST_FETCH;
               end
            end
            ST_MEM: begin
               r_pc    <= w_pc_inc;
               r_state <= ST_FETCH;
            end
            default: r_state <= ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core with behavioural ROM, RAM and register file.
module tb_mc_core;

   localparam logic [4:0] T_ADDI = 5'b00101;
   localparam logic [4:0] T_SW   = 5'b00111;
   localparam logic [4:0] T_LW   = 5'b01000;
   localparam logic [4:0] T_J    = 5'b00001;
   localparam logic [4:0] T_BNE  = 5'b00010;
   localparam logic [4:0] T_JAL  = 5'b00011;
   localparam logic [4:0] T_JR   = 5'b00100;
   localparam logic [4:0] T_BLT  = 5'b00110;
   localparam logic [4:0] T_BEX  = 5'b10110;
   localparam logic [4:0] T_SETX = 5'b10101;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] address_imem;
   logic [31:0] q_imem;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [4:0]  ctrl_readRegA;
   logic [4:0]  ctrl_readRegB;
   logic [31:0] data_writeReg;
   logic [31:0] data_readRegA;
   logic [31:0] data_readRegB;
   logic        wren;
   logic [31:0] address_dmem;
   logic [31:0] data;
   logic [31:0] q_dmem;

   logic [31:0] rom [0:63];
   logic [31:0] ram [0:63];
   logic [31:0] rf  [0:31];
   logic        rf_clr = 1'b0;

   int total = 0;
   int bad   = 0;

   int          cyc;
   int          we_cnt;
   int          we_cyc [0:7];
   int          wren_cnt;
   int          wren_cyc;
   logic [31:0] wren_addr;
   logic [31:0] wren_data;

   mc_core #(.RESET_PC(32'd0)) dut (
      .clock            (clock),
      .reset            (reset),
      .address_imem     (address_imem),
      .q_imem           (q_imem),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .ctrl_readRegA    (ctrl_readRegA),
      .ctrl_readRegB    (ctrl_readRegB),
      .data_writeReg    (data_writeReg),
      .data_readRegA    (data_readRegA),
      .data_readRegB    (data_readRegB),
      .wren             (wren),
      .address_dmem     (address_dmem),
      .data             (data),
      .q_dmem           (q_dmem)
   );

   always #5 clock = ~clock;

   always @(posedge clock) q_imem <= rom[address_imem[5:0]];

   always @(posedge clock) begin
      if (wren) ram[address_dmem[5:0]] <= data;
      q_dmem <= ram[address_dmem[5:0]];
   end

   always @(posedge clock) begin
      if (rf_clr) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      end else if (ctrl_writeEnable) begin
         rf[ctrl_writeReg] <= data_writeReg;
      end
   end
   assign data_readRegA = rf[ctrl_readRegA];
   assign data_readRegB = rf[ctrl_readRegB];

   // Cycle numbering: cycle 1 is the first cycle after reset is released
   always @(negedge clock) begin
      if (reset) begin
         cyc      <= 0;
         we_cnt   <= 0;
         wren_cnt <= 0;
      end else begin
         cyc <= cyc + 1;
         if (ctrl_writeEnable) begin
            if (we_cnt < 8) we_cyc[we_cnt] <= cyc + 1;
            we_cnt <= we_cnt + 1;
         end
         if (wren) begin
            wren_cnt  <= wren_cnt + 1;
            wren_cyc  <= cyc + 1;
            wren_addr <= address_dmem;
            wren_data <= data;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] sh,
                                         input logic [4:0] fn);
      return {5'b00000, rd, rs, rt, sh, fn, 2'b00};
   endfunction

   function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [16:0] n);
      return {op, rd, rs, n};
   endfunction

   function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [26:0] t);
      return {op, t};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = 32'd0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      rf_clr = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      rf_clr = 1'b0;
      check("rst_pc",   address_imem, 32'd0);
      check("rst_we",   {31'd0, ctrl_writeEnable}, 32'd0);
      check("rst_wren", {31'd0, wren}, 32'd0);
      check("rst_dadr", address_dmem, 32'd0);
      check("rst_wdat", data_writeReg, 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      // arithmetic chain plus a mul treated as nop
      clear_rom();
      rom[0] = enc_i(T_ADDI, 5'd1, 5'd0, 17'd5);
      rom[1] = enc_i(T_ADDI, 5'd2, 5'd0, 17'd7);
      rom[2] = enc_r(5'd3, 5'd1, 5'd2, 5'd0, 5'b00000);
      rom[3] = enc_r(5'd4, 5'd1, 5'd2, 5'd0, 5'b00110);
      do_reset();
      step(12);
      check("t1_r1", rf[1], 32'd5);
      check("t1_r2", rf[2], 32'd7);
      check("t1_r3", rf[3], 32'd12);
      check("t1_mul_nop_r4", rf[4], 32'd0);
      check("t1_we_cnt", we_cnt, 3);
      check("t1_we_cyc0", we_cyc[0], 3);
      check("t1_we_cyc1", we_cyc[1], 6);
      check("t1_we_cyc2", we_cyc[2], 9);
      check("t1_wren_cnt", wren_cnt, 0);
      check("t1_pc", address_imem, 32'd4);

      // sign-extended immediate and shifts
      clear_rom();
      rom[0] = enc_i(T_ADDI, 5'd1, 5'd0, 17'h1FFFF);
      rom[1] = enc_r(5'd2, 5'd1, 5'd0, 5'd4, 5'b00101);
      rom[2] = enc_r(5'd3, 5'd1, 5'd0, 5'd31, 5'b00100);
      do_reset();
      step(9);
      check("t2_r1", rf[1], 32'hFFFF_FFFF);
      check("t2_sra", rf[2], 32'hFFFF_FFFF);
      check("t2_sll", rf[3], 32'h8000_0000);

      // overflow reporting through r30
      clear_rom();
      rom[0] = enc_i(T_ADDI, 5'd1, 5'd0, 17'h0FFFF);
      rom[1] = enc_r(5'd1, 5'd1, 5'd0, 5'd15, 5'b00100);
      rom[2] = enc_i(T_ADDI, 5'd5, 5'd0, 17'h07FFF);
      rom[3] = enc_r(5'd1, 5'd1, 5'd5, 5'd0, 5'b00011);
      rom[4] = enc_r(5'd2, 5'd1, 5'd1, 5'd0, 5'b00000);
      rom[5] = enc_i(T_ADDI, 5'd6, 5'd0, 17'd1);
      rom[6] = enc_r(5'd7, 5'd6, 5'd0, 5'd31, 5'b00100);
      rom[7] = enc_r(5'd8, 5'd7, 5'd6, 5'd0, 5'b00001);
      rom[8] = enc_i(T_ADDI, 5'd9, 5'd1, 17'd1);
      do_reset();
      step(15);
      check("t3_r1_max", rf[1], 32'h7FFF_FFFF);
      check("t3_add_ovf_r2", rf[2], 32'd0);
      check("t3_add_ovf_r30", rf[30], 32'd1);
      step(9);
      check("t3_r7_min", rf[7], 32'h8000_0000);
      check("t3_sub_ovf_r8", rf[8], 32'd0);
      check("t3_sub_ovf_r30", rf[30], 32'd3);
      step(3);
      check("t3_addi_ovf_r9", rf[9], 32'd0);
      check("t3_addi_ovf_r30", rf[30], 32'd2);

      // store then load
      clear_rom();
      rom[0] = enc_i(T_ADDI, 5'd1, 5'd0, 17'd9);
      rom[1] = enc_i(T_SW,   5'd1, 5'd0, 17'd4);
      rom[2] = enc_i(T_LW,   5'd2, 5'd0, 17'd4);
      do_reset();
      step(9);
      check("t4_wren_cnt", wren_cnt, 1);
      check("t4_wren_cyc", wren_cyc, 6);
      check("t4_wren_addr", wren_addr, 32'd4);
      check("t4_wren_data", wren_data, 32'd9);
      check("t4_ram4", ram[4], 32'd9);
      check("t4_lw_pc_hold", address_imem, 32'd2);
      step(1);
      check("t4_lw_pc_next", address_imem, 32'd3);
      check("t4_lw_r2", rf[2], 32'd9);
      check("t4_we_cnt", we_cnt, 2);
      check("t4_lw_we_cyc", we_cyc[1], 10);

      // branches, jal and jr
      clear_rom();
      rom[0]  = enc_i(T_ADDI, 5'd1, 5'd0, 17'd1);
      rom[1]  = enc_i(T_ADDI, 5'd3, 5'd0, 17'h1FFFF);
      rom[2]  = enc_i(T_BNE,  5'd1, 5'd0, 17'd1);
      rom[3]  = enc_i(T_ADDI, 5'd2, 5'd0, 17'd55);
      rom[4]  = enc_i(T_BLT,  5'd1, 5'd3, 17'd2);
      rom[5]  = enc_j(T_JAL,  27'd10);
      rom[6]  = enc_i(T_ADDI, 5'd4, 5'd0, 17'd66);
      rom[7]  = enc_i(T_BLT,  5'd3, 5'd1, 17'd5);
      rom[8]  = enc_i(T_ADDI, 5'd6, 5'd0, 17'd88);
      rom[10] = enc_i(T_ADDI, 5'd5, 5'd0, 17'd77);
      rom[11] = enc_i(T_JR,   5'd31, 5'd0, 17'd0);
      rom[13] = enc_i(T_ADDI, 5'd7, 5'd0, 17'd99);
      do_reset();
      step(15);
      check("t5_jal_pc", address_imem, 32'd10);
      check("t5_jal_r31", rf[31], 32'd6);
      step(15);
      check("t5_bne_skip_r2", rf[2], 32'd0);
      check("t5_ret_r4", rf[4], 32'd66);
      check("t5_target_r5", rf[5], 32'd77);
      check("t5_blt_skip_r6", rf[6], 32'd0);
      check("t5_blt_tgt_r7", rf[7], 32'd99);
      check("t5_end_pc", address_imem, 32'd14);

      // setx / bex
      clear_rom();
      rom[0]  = enc_j(T_BEX,  27'd20);
      rom[1]  = enc_j(T_SETX, 27'd3);
      rom[2]  = enc_j(T_BEX,  27'd20);
      rom[20] = enc_i(T_ADDI, 5'd1, 5'd0, 17'd5);
      do_reset();
      step(3);
      check("t6_bex_nt_pc", address_imem, 32'd1);
      step(6);
      check("t6_setx_r30", rf[30], 32'd3);
      check("t6_bex_pc", address_imem, 32'd20);
      step(3);
      check("t6_tgt_r1", rf[1], 32'd5);

      // reset asserted in EXEC of an add aborts the write
      clear_rom();
      rom[0] = enc_i(T_ADDI, 5'd1, 5'd0, 17'd5);
      rom[1] = enc_r(5'd2, 5'd1, 5'd1, 5'd0, 5'b00000);
      do_reset();
      step(5);
      check("t7_pre_we", {31'd0, ctrl_writeEnable}, 32'd1);
      check("t7_pre_wdat", data_writeReg, 32'd10);
      reset = 1'b1;
      #1;
      check("t7_rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
      step(1);
      check("t7_abort_r2", rf[2], 32'd0);
      check("t7_abort_pc", address_imem, 32'd0);
      check("t7_keep_r1", rf[1], 32'd5);
      reset = 1'b0;
      step(6);
      check("t7_rerun_r2", rf[2], 32'd10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
